// File: rtl/uart_apb_master.sv
// APB3 initiator for the CoreUARTapb register map: single read/write transfers from a
// command port, optionally preceded by polling the status register for a masked pattern.
//
// state    | meaning
// IDLE     | ready for a command
// P_SETUP  | status read, APB setup phase
// P_ACCESS | status read, APB access phase (waits on PREADY)
// SETUP    | commanded transfer, APB setup phase
// ACCESS   | commanded transfer, APB access phase (waits on PREADY)
// RESP     | one-cycle response pulse
module uart_apb_master #(
    parameter int                    ADDR_WIDTH   = 5,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = 5'h10,
    parameter int                    POLL_TIMEOUT = 1024
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    input  logic                  CMD_POLL,
    input  logic [DATA_WIDTH-1:0] CMD_MASK,
    input  logic [DATA_WIDTH-1:0] CMD_MATCH,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CNT_W = (POLL_TIMEOUT < 1) ? 1 : $clog2(POLL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(POLL_TIMEOUT);

    typedef enum logic [2:0] {IDLE, P_SETUP, P_ACCESS, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n, cnt_inc;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata, cap_mask, cap_match;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic                  pwrite_n;
    logic [DATA_WIDTH-1:0] pwdata_n, rdata_n;
    logic                  err_n, timeout_n, poll_hit, accept;

    assign accept = CMD_VALID && CMD_READY;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        paddr_n   = PADDR;
        pwrite_n  = PWRITE;
        pwdata_n  = PWDATA;
        rdata_n   = RSP_RDATA;
        err_n     = RSP_ERR;
        timeout_n = RSP_TIMEOUT;
        cnt_inc   = cnt + CNT_W'(1);
        poll_hit  = ((PRDATA & cap_mask) == (cap_match & cap_mask));
        case (state)
            IDLE: begin
                // Outputs are registered from the next state, so APB fields come straight from the command inputs here.
                if (accept) begin
                    cnt_n = '0;
                    if (CMD_POLL) begin
                        state_n  = P_SETUP;
                        paddr_n  = STATUS_ADDR;
                        pwrite_n = 1'b0;
                    end else begin
                        state_n  = SETUP;
                        paddr_n  = CMD_ADDR;
                        pwrite_n = CMD_WRITE;
                        pwdata_n = CMD_WDATA;
                    end
                end
            end
            P_SETUP: state_n = P_ACCESS;
            P_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_n   = RESP;
                        err_n     = 1'b1;
                        timeout_n = 1'b0;
                        cnt_n     = '0;
                    end else if (poll_hit) begin
                        state_n  = SETUP;
                        cnt_n    = '0;
                        paddr_n  = cap_addr;
                        pwrite_n = cap_write;
                        pwdata_n = cap_wdata;
                    end else if ((POLL_TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
                        state_n   = RESP;
                        err_n     = 1'b0;
                        timeout_n = 1'b1;
                        cnt_n     = '0;
                    end else begin
                        state_n = P_SETUP;
                        cnt_n   = cnt_inc;
                    end
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_n   = RESP;
                    err_n     = PSLVERR;
                    timeout_n = 1'b0;
                    if (!cap_write) rdata_n = PRDATA;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_write   <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
            cap_mask    <= '0;
            cap_match   <= '0;
            CMD_READY   <= 1'b1;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            CMD_READY   <= (state_n == IDLE);
            RSP_VALID   <= (state_n == RESP);
            RSP_RDATA   <= rdata_n;
            RSP_ERR     <= err_n;
            RSP_TIMEOUT <= timeout_n;
            PADDR       <= paddr_n;
            PSEL        <= (state_n == P_SETUP) || (state_n == P_ACCESS) ||
                           (state_n == SETUP)   || (state_n == ACCESS);
            PENABLE     <= (state_n == P_ACCESS) || (state_n == ACCESS);
            PWRITE      <= pwrite_n;
            PWDATA      <= pwdata_n;
            if (accept) begin
                cap_write <= CMD_WRITE;
                cap_addr  <= CMD_ADDR;
                cap_wdata <= CMD_WDATA;
                cap_mask  <= CMD_MASK;
                cap_match <= CMD_MATCH;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Bench for uart_apb_master: behavioural APB slave with wait/error injection, scoreboards
// for expected APB transfers and command responses, per-scenario latency checks.
module tb_uart_apb_master;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0, CMD_POLL = 1'b0;
    logic [4:0] CMD_ADDR = '0;
    logic [7:0] CMD_WDATA = '0, CMD_MASK = '0, CMD_MATCH = '0;
    logic       RSP_VALID, RSP_ERR, RSP_TIMEOUT;
    logic [7:0] RSP_RDATA;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = '0;
    logic       PREADY = 1'b0, PSLVERR = 1'b0;

    uart_apb_master #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .STATUS_ADDR(5'h10), .POLL_TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR),
        .CMD_WDATA(CMD_WDATA), .CMD_POLL(CMD_POLL), .CMD_MASK(CMD_MASK), .CMD_MATCH(CMD_MATCH),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed { logic [4:0] addr; logic write; logic [7:0] wdata; } xfer_t;
    typedef struct packed { logic [7:0] rdata; logic err; logic to; } rsp_t;
    typedef struct packed { logic [7:0] data; logic err; } slv_t;

    xfer_t exp_xfer[$];
    rsp_t  exp_rsp[$];
    slv_t  slv_q[$];

    int checks = 0;
    int passed = 0;
    int wait_cfg = 0;
    int wait_left = 0;
    logic setup_seen = 1'b0, acc_first = 1'b0;
    logic [4:0] a0;
    logic       w0;
    logic [7:0] d0;

    // APB slave: decides PREADY/PRDATA on the falling edge, checks each completed transfer.
    always @(negedge PCLK) begin
        slv_t  s;
        xfer_t x;
        if (PSEL && !PENABLE) begin
            setup_seen = 1'b1;
            acc_first  = 1'b1;
            wait_left  = wait_cfg;
            PREADY     = 1'b0;
            PSLVERR    = 1'b0;
        end else if (PSEL && PENABLE) begin
            if (acc_first) begin
                checks++;
                if (setup_seen !== 1'b1) $display("FAIL apb_setup_phase: setup seen %b, required 1", setup_seen);
                else passed++;
                a0 = PADDR; w0 = PWRITE; d0 = PWDATA;
                acc_first  = 1'b0;
                setup_seen = 1'b0;
            end else begin
                checks++;
                if ({PADDR, PWRITE, PWDATA} !== {a0, w0, d0})
                    $display("FAIL apb_stable: addr/wr/wdata %h/%b/%h, required %h/%b/%h", PADDR, PWRITE, PWDATA, a0, w0, d0);
                else passed++;
            end
            if (wait_left > 0) begin
                PREADY = 1'b0;
                wait_left--;
            end else begin
                if (slv_q.size() > 0) s = slv_q.pop_front();
                else s = '{data: 8'h00, err: 1'b0};
                PREADY  = 1'b1;
                PRDATA  = PWRITE ? 8'hEE : s.data;
                PSLVERR = s.err;
                checks++;
                if (exp_xfer.size() == 0) begin
                    $display("FAIL apb_xfer: unexpected transfer addr %h wr %b wdata %h, required none", PADDR, PWRITE, PWDATA);
                end else begin
                    x = exp_xfer.pop_front();
                    if (PADDR !== x.addr || PWRITE !== x.write || (x.write && PWDATA !== x.wdata))
                        $display("FAIL apb_xfer: addr/wr/wdata %h/%b/%h, required %h/%b/%h", PADDR, PWRITE, PWDATA, x.addr, x.write, x.wdata);
                    else passed++;
                end
            end
        end else begin
            PREADY     = 1'b0;
            PSLVERR    = 1'b0;
            setup_seen = 1'b0;
            acc_first  = 1'b0;
        end
    end

    always @(negedge PCLK) begin
        rsp_t r;
        if (RSP_VALID === 1'b1) begin
            checks++;
            if (exp_rsp.size() == 0) begin
                $display("FAIL rsp: unexpected response rdata %h err %b to %b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT);
            end else begin
                r = exp_rsp.pop_front();
                if ({RSP_RDATA, RSP_ERR, RSP_TIMEOUT} !== {r.rdata, r.err, r.to})
                    $display("FAIL rsp: rdata/err/to %h/%b/%b, required %h/%b/%b", RSP_RDATA, RSP_ERR, RSP_TIMEOUT, r.rdata, r.err, r.to);
                else passed++;
            end
        end
    end

    // Issue one command at a falling edge and measure cycles from the accepting edge to RSP_VALID.
    task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d, input logic p,
                        input logic [7:0] m, input logic [7:0] mt, input int exp_lat, input string name);
        int  n;
        logic ready_bad;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 200) begin @(negedge PCLK); n++; end
        CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d; CMD_POLL = p; CMD_MASK = m; CMD_MATCH = mt;
        CMD_VALID = 1'b1;
        @(posedge PCLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'($urandom); CMD_ADDR = 5'($urandom); CMD_WDATA = 8'($urandom);
        CMD_POLL = 1'($urandom); CMD_MASK = 8'($urandom); CMD_MATCH = 8'($urandom);
        n = 0;
        ready_bad = 1'b0;
        do begin
            @(negedge PCLK);
            n++;
            if (CMD_READY !== 1'b0) ready_bad = 1'b1;
        end while (RSP_VALID !== 1'b1 && n < 200);
        checks++;
        if (n !== exp_lat) $display("FAIL %s_latency: %0d cycles, required %0d", name, n, exp_lat);
        else passed++;
        checks++;
        if (ready_bad !== 1'b0) $display("FAIL %s_cmd_ready: ready seen high while busy, required low", name);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if (CMD_READY !== 1'b1) $display("FAIL reset_cmd_ready: %b, required 1", CMD_READY); else passed++;
        checks++;
        if ({PSEL, PENABLE, RSP_VALID, RSP_ERR, RSP_TIMEOUT} !== 5'b0)
            $display("FAIL reset_ctrl: %b, required 00000", {PSEL, PENABLE, RSP_VALID, RSP_ERR, RSP_TIMEOUT});
        else passed++;
        checks++;
        if ({RSP_RDATA, PADDR, PWRITE, PWDATA} !== 22'b0)
            $display("FAIL reset_data: rdata %h paddr %h pwrite %b pwdata %h, required 0", RSP_RDATA, PADDR, PWRITE, PWDATA);
        else passed++;
        PRESET = 1'b0;
    endtask

    task automatic test_write();
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        exp_xfer.push_back('{addr: 5'h08, write: 1'b1, wdata: 8'h1A});
        exp_rsp.push_back('{rdata: 8'h00, err: 1'b0, to: 1'b0});
        send(1'b1, 5'h08, 8'h1A, 1'b0, 8'h00, 8'h00, 3, "write");
        checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA} !== {2'b00, 5'h08, 1'b1, 8'h1A})
            $display("FAIL write_hold: psel/pen %b%b paddr %h pwrite %b pwdata %h, required 00 08 1 1a", PSEL, PENABLE, PADDR, PWRITE, PWDATA);
        else passed++;
    endtask

    task automatic test_read_wait();
        wait_cfg = 2;
        slv_q.push_back('{data: 8'h03, err: 1'b0});
        exp_xfer.push_back('{addr: 5'h10, write: 1'b0, wdata: 8'h00});
        exp_rsp.push_back('{rdata: 8'h03, err: 1'b0, to: 1'b0});
        send(1'b0, 5'h10, 8'h00, 1'b0, 8'h00, 8'h00, 5, "read_wait");
        wait_cfg = 0;
    endtask

    task automatic test_poll_write();
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        slv_q.push_back('{data: 8'h01, err: 1'b0});
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        for (int i = 0; i < 3; i++) exp_xfer.push_back('{addr: 5'h10, write: 1'b0, wdata: 8'h00});
        exp_xfer.push_back('{addr: 5'h00, write: 1'b1, wdata: 8'h55});
        exp_rsp.push_back('{rdata: 8'h03, err: 1'b0, to: 1'b0});
        send(1'b1, 5'h00, 8'h55, 1'b1, 8'h01, 8'h01, 9, "poll_write");
    endtask

    task automatic test_poll_timeout();
        for (int i = 0; i < 4; i++) begin
            slv_q.push_back('{data: 8'h00, err: 1'b0});
            exp_xfer.push_back('{addr: 5'h10, write: 1'b0, wdata: 8'h00});
        end
        exp_rsp.push_back('{rdata: 8'h03, err: 1'b0, to: 1'b1});
        send(1'b0, 5'h05, 8'h00, 1'b1, 8'hFF, 8'h80, 9, "poll_timeout");
    endtask

    task automatic test_errors();
        slv_q.push_back('{data: 8'h42, err: 1'b1});
        exp_xfer.push_back('{addr: 5'h10, write: 1'b0, wdata: 8'h00});
        exp_rsp.push_back('{rdata: 8'h03, err: 1'b1, to: 1'b0});
        send(1'b1, 5'h07, 8'hAA, 1'b1, 8'h01, 8'h01, 3, "poll_err");
        slv_q.push_back('{data: 8'h77, err: 1'b1});
        exp_xfer.push_back('{addr: 5'h04, write: 1'b0, wdata: 8'h00});
        exp_rsp.push_back('{rdata: 8'h77, err: 1'b1, to: 1'b0});
        send(1'b0, 5'h04, 8'h00, 1'b0, 8'h00, 8'h00, 3, "data_err");
    endtask

    task automatic test_mask_zero();
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        slv_q.push_back('{data: 8'h3C, err: 1'b0});
        exp_xfer.push_back('{addr: 5'h10, write: 1'b0, wdata: 8'h00});
        exp_xfer.push_back('{addr: 5'h02, write: 1'b0, wdata: 8'h00});
        exp_rsp.push_back('{rdata: 8'h3C, err: 1'b0, to: 1'b0});
        send(1'b0, 5'h02, 8'h00, 1'b1, 8'h00, 8'hFF, 5, "mask_zero");
    endtask

    task automatic test_back_to_back();
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        exp_xfer.push_back('{addr: 5'h0B, write: 1'b1, wdata: 8'hC3});
        exp_rsp.push_back('{rdata: 8'h3C, err: 1'b0, to: 1'b0});
        send(1'b1, 5'h0B, 8'hC3, 1'b0, 8'h00, 8'h00, 3, "b2b_write");
        @(negedge PCLK);
        checks++;
        if (CMD_READY !== 1'b1) $display("FAIL b2b_ready: %b one cycle after response, required 1", CMD_READY);
        else passed++;
        slv_q.push_back('{data: 8'h99, err: 1'b0});
        exp_xfer.push_back('{addr: 5'h06, write: 1'b0, wdata: 8'h00});
        exp_rsp.push_back('{rdata: 8'h99, err: 1'b0, to: 1'b0});
        send(1'b0, 5'h06, 8'h00, 1'b0, 8'h00, 8'h00, 3, "b2b_read");
    endtask

    task automatic test_reset_abort();
        int n;
        wait_cfg = 20;
        n = 0;
        while (CMD_READY !== 1'b1 && n < 50) begin @(negedge PCLK); n++; end
        CMD_WRITE = 1'b0; CMD_ADDR = 5'h03; CMD_POLL = 1'b0; CMD_VALID = 1'b1;
        @(posedge PCLK);
        #1 CMD_VALID = 1'b0;
        n = 0;
        do begin @(negedge PCLK); n++; end while (PENABLE !== 1'b1 && n < 50);
        checks++;
        if (PENABLE !== 1'b1) $display("FAIL abort_reach_access: penable %b, required 1", PENABLE);
        else passed++;
        PRESET = 1'b1;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, CMD_READY, RSP_VALID} !== 4'b0010)
            $display("FAIL abort_state: psel/pen/ready/rsp %b, required 0010", {PSEL, PENABLE, CMD_READY, RSP_VALID});
        else passed++;
        checks++;
        if (RSP_RDATA !== 8'h00) $display("FAIL abort_rdata: %h, required 00", RSP_RDATA); else passed++;
        wait_cfg = 0;
        slv_q.push_back('{data: 8'h00, err: 1'b0});
        exp_xfer.push_back('{addr: 5'h09, write: 1'b1, wdata: 8'h5A});
        exp_rsp.push_back('{rdata: 8'h00, err: 1'b0, to: 1'b0});
        send(1'b1, 5'h09, 8'h5A, 1'b0, 8'h00, 8'h00, 3, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_poll_write();
        test_poll_timeout();
        test_errors();
        test_mask_zero();
        test_back_to_back();
        test_reset_abort();
        repeat (4) @(negedge PCLK);
        checks++;
        if (exp_xfer.size() !== 0) $display("FAIL xfer_drain: %0d transfers outstanding, required 0", exp_xfer.size());
        else passed++;
        checks++;
        if (exp_rsp.size() !== 0) $display("FAIL rsp_drain: %0d responses outstanding, required 0", exp_rsp.size());
        else passed++;
        checks++;
        if (slv_q.size() !== 0) $display("FAIL slave_drain: %0d slave entries unused, required 0", slv_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
